// File: rtl/riscv_pkg.sv
// Shared constants and types for the register-file write path.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO of pending register writes, exposing every slot
// so the top level can run hazard compares against buffered destinations.
module wb_fifo #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [AW-1:0]             push_rd,
  input  logic [XLEN-1:0]           push_data,
  input  logic                      pop,
  output logic [AW-1:0]             head_rd,
  output logic [XLEN-1:0]           head_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH-1:0][AW-1:0]  entry_rd,
  output logic [DEPTH-1:0]          entry_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic            push_ok;
  logic            pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: payload storage has no reset; the pointers and count alone say which slots are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign count     = cnt;

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PW-1:0] offset;
    assign offset         = PW'(i) - rd_ptr;
    assign entry_valid[i] = ({1'b0, offset} < cnt);
    assign entry_rd[i]    = rd_mem[i];
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write driver: buffers ALU and load results, round-robins
// one write per cycle onto the write port and flags pending destinations.
module reg_writeback #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int AW    = riscv_pkg::AW,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            reg_write,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] write_data,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            pend1,
  output logic            pend2,
  output logic            idle
);

  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                     alu_push, mem_push;
  logic                     alu_pop, mem_pop;
  logic [AW-1:0]            alu_head_rd, mem_head_rd;
  logic [XLEN-1:0]          alu_head_data, mem_head_data;
  logic [CW-1:0]            alu_count, mem_count;
  logic                     alu_full, mem_full;
  logic                     alu_empty, mem_empty;
  logic [DEPTH-1:0][AW-1:0] alu_entry_rd, mem_entry_rd;
  logic [DEPTH-1:0]         alu_entry_valid, mem_entry_valid;

  src_e last_grant;
  src_e grant_src;
  logic grant_valid;

  // Ready never looks at a same-cycle pop, so a full FIFO always stalls one cycle.
  assign alu_ready = reset & ~alu_full;
  assign mem_ready = reset & ~mem_full;

  // Writes to x0 finish the handshake but are dropped here.
  assign alu_push = alu_valid & alu_ready & (alu_rd != AW'(REG_ZERO));
  assign mem_push = mem_valid & mem_ready & (mem_rd != AW'(REG_ZERO));

  wb_fifo #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) u_alu_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push        (alu_push),
    .push_rd     (alu_rd),
    .push_data   (alu_data),
    .pop         (alu_pop),
    .head_rd     (alu_head_rd),
    .head_data   (alu_head_data),
    .count       (alu_count),
    .full        (alu_full),
    .empty       (alu_empty),
    .entry_rd    (alu_entry_rd),
    .entry_valid (alu_entry_valid)
  );

  wb_fifo #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) u_mem_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push        (mem_push),
    .push_rd     (mem_rd),
    .push_data   (mem_data),
    .pop         (mem_pop),
    .head_rd     (mem_head_rd),
    .head_data   (mem_head_data),
    .count       (mem_count),
    .full        (mem_full),
    .empty       (mem_empty),
    .entry_rd    (mem_entry_rd),
    .entry_valid (mem_entry_valid)
  );

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_ALU;
    if (!alu_empty && !mem_empty) begin
      grant_valid = 1'b1;
      grant_src   = (last_grant == SRC_ALU) ? SRC_MEM : SRC_ALU;
    end else if (!alu_empty) begin
      grant_valid = 1'b1;
      grant_src   = SRC_ALU;
    end else if (!mem_empty) begin
      grant_valid = 1'b1;
      grant_src   = SRC_MEM;
    end
  end

  assign alu_pop = grant_valid && (grant_src == SRC_ALU);
  assign mem_pop = grant_valid && (grant_src == SRC_MEM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write  <= 1'b0;
      rd         <= '0;
      write_data <= '0;
      last_grant <= SRC_ALU;
    end else begin
      reg_write <= grant_valid;
      if (grant_valid) begin
        last_grant <= grant_src;
        rd         <= (grant_src == SRC_MEM) ? mem_head_rd   : alu_head_rd;
        write_data <= (grant_src == SRC_MEM) ? mem_head_data : alu_head_data;
      end
    end
  end

  // Hazard query covers both FIFOs plus the write currently on the port.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_entry_valid[i] && (alu_entry_rd[i] == rs1)) pend1 = 1'b1;
      if (mem_entry_valid[i] && (mem_entry_rd[i] == rs1)) pend1 = 1'b1;
      if (alu_entry_valid[i] && (alu_entry_rd[i] == rs2)) pend2 = 1'b1;
      if (mem_entry_valid[i] && (mem_entry_rd[i] == rs2)) pend2 = 1'b1;
    end
    if (reg_write && (rd == rs1)) pend1 = 1'b1;
    if (reg_write && (rd == rs2)) pend2 = 1'b1;
    if (rs1 == AW'(REG_ZERO)) pend1 = 1'b0;
    if (rs2 == AW'(REG_ZERO)) pend2 = 1'b0;
  end

  assign idle = (alu_count == '0) && (mem_count == '0) && !reg_write;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed table, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_reg_writeback;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            alu_valid = 1'b0, mem_valid = 1'b0;
  logic            alu_ready, mem_ready;
  logic [AW-1:0]   alu_rd = '0, mem_rd = '0, rs1 = '0, rs2 = '0;
  logic [XLEN-1:0] alu_data = '0, mem_data = '0;
  logic            reg_write, pend1, pend2, idle;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] write_data;

  always #5 clk = ~clk;

  reg_writeback #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .reg_write  (reg_write),
    .rd         (rd),
    .write_data (write_data),
    .rs1        (rs1),
    .rs2        (rs2),
    .pend1      (pend1),
    .pend2      (pend2),
    .idle       (idle)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: actual=%0h required=%0h", phase, name, act, exp);
    end
  endtask

  // Reference model: two queues of pending writes and the last granted source.
  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t             alu_q[$];
  wr_t             mem_q[$];
  bit              m_last_mem;
  bit              m_wr;
  logic [AW-1:0]   m_rd;
  logic [XLEN-1:0] m_data;
  bit              acc_alu, acc_mem;

  task automatic model_reset();
    alu_q.delete();
    mem_q.delete();
    m_last_mem = 1'b0;
    m_wr       = 1'b0;
    m_rd       = '0;
    m_data     = '0;
  endtask

  task automatic model_edge();
    bit  take_a, take_m, use_mem;
    wr_t w;
    if (!reset) begin
      model_reset();
      return;
    end
    take_a = alu_valid && (alu_q.size() < DEPTH);
    take_m = mem_valid && (mem_q.size() < DEPTH);
    if (alu_q.size() > 0 && mem_q.size() > 0) use_mem = !m_last_mem;
    else use_mem = (mem_q.size() > 0);
    if (alu_q.size() > 0 || mem_q.size() > 0) begin
      w          = use_mem ? mem_q.pop_front() : alu_q.pop_front();
      m_wr       = 1'b1;
      m_rd       = w.rd;
      m_data     = w.data;
      m_last_mem = use_mem;
    end else begin
      m_wr = 1'b0;
    end
    if (take_a && alu_rd != 0) alu_q.push_back('{alu_rd, alu_data});
    if (take_m && mem_rd != 0) mem_q.push_back('{mem_rd, mem_data});
  endtask

  function automatic bit model_pend(input logic [AW-1:0] rs);
    if (rs == 0) return 1'b0;
    foreach (alu_q[i]) if (alu_q[i].rd == rs) return 1'b1;
    foreach (mem_q[i]) if (mem_q[i].rd == rs) return 1'b1;
    return m_wr && (m_rd == rs);
  endfunction

  task automatic check_all();
    check("alu_ready",  alu_ready,  reset && (alu_q.size() < DEPTH));
    check("mem_ready",  mem_ready,  reset && (mem_q.size() < DEPTH));
    check("reg_write",  reg_write,  m_wr);
    check("rd",         rd,         m_rd);
    check("write_data", write_data, m_data);
    check("pend1",      pend1,      model_pend(rs1));
    check("pend2",      pend2,      model_pend(rs2));
    check("idle",       idle,       alu_q.size() == 0 && mem_q.size() == 0 && !m_wr);
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    #1;
    check_all();
    acc_alu = alu_valid && alu_ready;
    acc_mem = mem_valid && mem_ready;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                       input logic mv, input logic [AW-1:0] mrd, input logic [XLEN-1:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
  endtask

  typedef struct {
    logic            av;
    logic [AW-1:0]   ard;
    logic [XLEN-1:0] ad;
    logic            mv;
    logic [AW-1:0]   mrd;
    logic [XLEN-1:0] md;
    logic            ewr;
    logic [AW-1:0]   erd;
    logic [XLEN-1:0] ewd;
    logic            eidle;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] obs[$];
    int  a_idx, m_idx, cyc;
    bit  seen_block;

    // Round-robin conflict pair, single-write latency, then a dropped x0 load.
    tbl[0] = '{1, 1, 1,     1, 2, 2,        0, 0, 0,     0};
    tbl[1] = '{1, 3, 3,     1, 4, 4,        1, 2, 2,     0};
    tbl[2] = '{0, 0, 0,     0, 0, 0,        1, 1, 1,     0};
    tbl[3] = '{0, 0, 0,     0, 0, 0,        1, 4, 4,     0};
    tbl[4] = '{0, 0, 0,     0, 0, 0,        1, 3, 3,     0};
    tbl[5] = '{1, 5, 'hAA,  0, 0, 0,        0, 3, 3,     0};
    tbl[6] = '{0, 0, 0,     0, 0, 0,        1, 5, 'hAA,  0};
    tbl[7] = '{0, 0, 0,     0, 0, 0,        0, 5, 'hAA,  1};
    tbl[8] = '{0, 0, 0,     1, 0, 'hDEAD,   0, 5, 'hAA,  1};
    tbl[9] = '{0, 0, 0,     0, 0, 0,        0, 5, 'hAA,  1};

    model_reset();
    phase = "reset";
    @(negedge clk);
    rs1 = 5'd3; rs2 = 5'd0;
    step();
    step();
    reset = 1'b1;
    rs1 = '0;

    phase = "table";
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].mv, tbl[i].mrd, tbl[i].md);
      step();
      #1;
      check($sformatf("row%0d_reg_write", i), reg_write, tbl[i].ewr);
      check($sformatf("row%0d_rd", i), rd, tbl[i].erd);
      check($sformatf("row%0d_write_data", i), write_data, tbl[i].ewd);
      check($sformatf("row%0d_idle", i), idle, tbl[i].eidle);
    end

    phase = "reset_mid";
    drive(1, 5'd3, 32'd7, 0, 0, 0);
    rs1 = 5'd3;
    step();
    reset = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("alu_ready_in_reset", alu_ready, 1'b0);
    check("pend1_in_reset", pend1, 1'b0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      check("no_x3_write", reg_write, 1'b0);
      check("idle_after_reset", idle, 1'b1);
    end

    phase = "hazard";
    rs1 = 5'd8; rs2 = 5'd9;
    step();
    #1;
    check("pend1_before", pend1, 1'b0);
    drive(1, 5'd8, 32'h88, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("pend1_queued", pend1, 1'b1);
    check("pend2_queued", pend2, 1'b0);
    step();
    #1;
    check("write_rd8", reg_write && (rd == 5'd8), 1'b1);
    check("pend1_on_port", pend1, 1'b1);
    step();
    #1;
    check("pend1_cleared", pend1, 1'b0);
    check("reg_write_one_cycle", reg_write, 1'b0);

    phase = "backpressure";
    rs1 = '0; rs2 = '0;
    a_idx = 0; m_idx = 0; cyc = 0; seen_block = 0;
    while ((a_idx < 4 || obs.size() < 4) && cyc < 40) begin
      drive(a_idx < 4, AW'(6 + a_idx), 32'h600 + a_idx,
            1, AW'(16 + (m_idx % 15)), 32'h1000 + m_idx);
      step();
      if (!seen_block && alu_valid && !acc_alu) begin
        seen_block = 1;
        check("accepts_before_full", a_idx, 2);
      end
      if (acc_alu) a_idx++;
      if (acc_mem) m_idx++;
      #1;
      if (reg_write && rd >= 6 && rd <= 9) obs.push_back(rd);
      cyc++;
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    check("alu_blocked_seen", seen_block, 1'b1);
    check("alu_writes_count", obs.size(), 4);
    foreach (obs[i]) check($sformatf("alu_order%0d", i), obs[i], 6 + i);

    phase = "random";
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        reset = 1'b0;
        model_reset();
        step();
        reset = 1'b1;
      end
      if (!(alu_valid && !acc_alu)) begin
        alu_valid = ($urandom_range(0, 9) < 6);
        alu_rd    = AW'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!(mem_valid && !acc_mem)) begin
        mem_valid = ($urandom_range(0, 9) < 5);
        mem_rd    = AW'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      rs1 = AW'($urandom_range(0, 7));
      rs2 = AW'($urandom_range(0, 7));
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step();
    #1;
    check("final_idle", idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
